mcu_block_scheduler: RTL and testbench



---
 rtl/mcu_block_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_mcu_block_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_block_scheduler.sv
// Interleaves Y/Cb/Cr 8x8 zigzag blocks into one entropy-coder stream in MCU order.
// Define RESTART_EN to add restart-marker insertion (RSTM state and its ports).
module mcu_block_scheduler #(
    parameter int DATA_WIDTH = 10,
    parameter int Y_BLOCKS   = 4,
    parameter int GAP_CYCLES = 2,
    parameter int MCU_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [MCU_W-1:0]        mcu_total,
`ifdef RESTART_EN
    input  logic [MCU_W-1:0]        restart_interval,
    output logic                    out_rst_marker,
    output logic [2:0]              out_rst_idx,
`endif
    input  logic [2:0]              src_valid,
    input  logic [3*DATA_WIDTH-1:0] src_data,
    output logic [2:0]              src_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_done,
    output logic [1:0]              out_comp,
    output logic                    out_chroma,
    output logic                    out_dc_reset,
    output logic                    busy,
    output logic                    frame_done
);
    // state  | meaning
    // IDLE   | waiting for frame_start
    // STREAM | passing coefficients of block blk from the selected source
    // GAP    | idle output cycles so the coder can finish end-of-block
    // RSTM   | one-cycle restart marker between MCUs (RESTART_EN only)
    // DONE   | frame_done pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        GAP    = 3'd2,
`ifdef RESTART_EN
        RSTM   = 3'd3,
`endif
        DONE   = 3'd4
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [2:0]    CB_BLK   = 3'(Y_BLOCKS);
    localparam logic [2:0]    LAST_BLK = 3'(Y_BLOCKS + 1);

    state_t                  state_q, state_d;
    logic [2:0]              blk_q;
    logic [MCU_W-1:0]        mcu_q;
    logic [MCU_W-1:0]        total_q;
    logic [5:0]              coef_q;
    logic [GW-1:0]           gap_q;
    logic                    dc_mcu_q;
    logic                    zero_done_q;

    logic [1:0]              sel;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_valid;
    logic                    xfer;
    logic [MCU_W-1:0]        mcu_next;
    logic                    restart_hit;

`ifdef RESTART_EN
    logic [MCU_W-1:0]        ri_q;
    logic [MCU_W-1:0]        rint_q;
    logic [2:0]              rcnt_q;

    // rint_q counts down MCUs until the next restart boundary
    assign restart_hit    = (ri_q != '0) && (rint_q == '0);
    assign out_rst_marker = (state_q == RSTM);
    assign out_rst_idx    = (state_q == RSTM) ? rcnt_q : 3'd0;
`else
    assign restart_hit    = 1'b0;
`endif

    always_comb begin
        sel = 2'd0;
        if (blk_q == CB_BLK) begin
            sel = 2'd1;
        end else if (blk_q == LAST_BLK) begin
            sel = 2'd2;
        end
    end

    always_comb begin
        sel_data  = src_data[DATA_WIDTH-1:0];
        sel_valid = src_valid[0];
        case (sel)
            2'd1: begin
                sel_data  = src_data[2*DATA_WIDTH-1:DATA_WIDTH];
                sel_valid = src_valid[1];
            end
            2'd2: begin
                sel_data  = src_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
                sel_valid = src_valid[2];
            end
            default: ;
        endcase
    end

    assign xfer     = (state_q == STREAM) && sel_valid;
    assign mcu_next = mcu_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (frame_start && (mcu_total != '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && (coef_q == 6'd63)) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if ((blk_q == LAST_BLK) && (mcu_next == total_q)) begin
                        state_d = DONE;
                    end else if ((blk_q == LAST_BLK) && restart_hit) begin
`ifdef RESTART_EN
                        state_d = RSTM;
`else
                        state_d = STREAM;
`endif
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
`ifdef RESTART_EN
            RSTM: state_d = STREAM;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q       <= '0;
            mcu_q       <= '0;
            total_q     <= '0;
            coef_q      <= '0;
            gap_q       <= '0;
            dc_mcu_q    <= 1'b0;
            zero_done_q <= 1'b0;
`ifdef RESTART_EN
            ri_q        <= '0;
            rint_q      <= '0;
            rcnt_q      <= '0;
`endif
        end else begin
            zero_done_q <= (state_q == IDLE) && frame_start && (mcu_total == '0);
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        total_q  <= mcu_total;
                        blk_q    <= '0;
                        mcu_q    <= '0;
                        coef_q   <= '0;
                        dc_mcu_q <= 1'b1;
`ifdef RESTART_EN
                        ri_q     <= restart_interval;
                        rint_q   <= restart_interval - 1'b1;
                        rcnt_q   <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        coef_q <= coef_q + 1'b1;
                        if (coef_q == 6'd63) begin
                            gap_q <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else if (blk_q == LAST_BLK) begin
                        blk_q    <= '0;
                        mcu_q    <= mcu_next;
                        dc_mcu_q <= restart_hit;
`ifdef RESTART_EN
                        rint_q   <= (rint_q == '0) ? (ri_q - 1'b1) : (rint_q - 1'b1);
`endif
                    end else begin
                        blk_q <= blk_q + 1'b1;
                    end
                end
`ifdef RESTART_EN
                RSTM: rcnt_q <= rcnt_q + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Registered output stage: data/tags hold between transfers, strobes do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_done     <= 1'b0;
            out_comp     <= 2'd0;
            out_chroma   <= 1'b0;
            out_dc_reset <= 1'b0;
        end else begin
            out_valid    <= xfer;
            out_done     <= xfer && (coef_q == 6'd63);
            out_dc_reset <= xfer && (coef_q == 6'd0) && dc_mcu_q;
            if (xfer) begin
                out_data   <= sel_data;
                out_comp   <= sel;
                out_chroma <= (sel != 2'd0);
            end
        end
    end

    always_comb begin
        src_ready = 3'b000;
        if (state_q == STREAM) begin
            src_ready[sel] = 1'b1;
        end
    end

    assign busy       = (state_q == STREAM) || (state_q == GAP)
`ifdef RESTART_EN
                        || (state_q == RSTM)
`endif
                        ;
    assign frame_done = (state_q == DONE) || zero_done_q;

endmodule

// File: tb/tb_mcu_block_scheduler.sv
// Directed bench for mcu_block_scheduler: expected coefficients are queued at each
// source handshake and compared when the DUT presents them on the output.
module tb_mcu_block_scheduler;
    localparam int DW  = 10;
    localparam int YB  = 4;
    localparam int GAP = 2;
    localparam int MW  = 16;
    localparam int NB  = YB + 2;
`ifdef RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    comp;
        logic          done;
        logic          dc;
        int            idle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [MW-1:0]   mcu_total;
    logic [2:0]      src_valid;
    logic [3*DW-1:0] src_data;
    logic [2:0]      src_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_done;
    logic [1:0]      out_comp;
    logic            out_chroma;
    logic            out_dc_reset;
    logic            busy;
    logic            frame_done;
`ifdef RESTART_EN
    logic [MW-1:0]   restart_interval;
    logic            out_rst_marker;
    logic [2:0]      out_rst_idx;
`endif

    mcu_block_scheduler #(
        .DATA_WIDTH(DW), .Y_BLOCKS(YB), .GAP_CYCLES(GAP), .MCU_W(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .mcu_total(mcu_total),
`ifdef RESTART_EN
        .restart_interval(restart_interval),
        .out_rst_marker(out_rst_marker),
        .out_rst_idx(out_rst_idx),
`endif
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_done(out_done),
        .out_comp(out_comp),
        .out_chroma(out_chroma),
        .out_dc_reset(out_dc_reset),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    int   pb, pm, pc;
    bit   first_blk, dc_mcu, mk_before;
    int   stalls, idle_run, out_cnt, fd_seen, mk_cnt, drop_left, cur_ri, fd_idle_exp;
    int   src_cnt [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (out_valid === 1'b1) begin
            out_cnt++;
            chk("out_has_expect", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("data", 32'(out_data), 32'(e.data));
                chk("comp", 32'(out_comp), 32'(e.comp));
                chk("chroma", 32'(out_chroma), 32'(e.comp != 2'd0));
                chk("done", 32'(out_done), 32'(e.done));
                chk("dc_reset", 32'(out_dc_reset), 32'(e.dc));
                chk("busy_during_out", 32'(busy), 32'd1);
                if (e.idle >= 0) chk("idle_before", 32'(idle_run), 32'(e.idle));
            end
            idle_run = 0;
        end else begin
            idle_run++;
            chk("idle_strobes", 32'({out_done, out_dc_reset}), 32'd0);
        end
        if (frame_done === 1'b1) begin
            fd_seen++;
            chk("fd_idle", 32'(idle_run), 32'(fd_idle_exp));
            chk("fd_q_empty", 32'(q.size()), 32'd0);
        end
`ifdef RESTART_EN
        if (out_rst_marker === 1'b1) begin
            chk("marker_idx", 32'(out_rst_idx), 32'(mk_cnt % 8));
            mk_cnt++;
        end
`endif
    endtask

    task automatic cycle(input bit abort, input bit fs);
        logic [2:0] hs;
        int         plan;
        exp_t       e;
        sample();
        plan = (pb < YB) ? 0 : ((pb == YB) ? 1 : 2);
        src_valid = 3'b111;
        if (drop_left > 0 && pm == 0 && pb == 0 && pc == 20) begin
            src_valid[0] = 1'b0;
            drop_left--;
            stalls++;
        end
        src_data = {DW'((src_cnt[2] % 64) | 256), DW'((src_cnt[1] % 64) | 128),
                    DW'(src_cnt[0] % 64)};
        frame_start = fs;
        rst = abort;
        hs = abort ? 3'b000 : (src_valid & src_ready);
        if (hs != 3'b000) begin
            chk("ready_sel", 32'(hs), 32'(3'b001 << plan));
            e.data = DW'(pc | (plan << 7));
            e.comp = 2'(plan);
            e.done = (pc == 63);
            e.dc   = (pc == 0) && dc_mcu;
            e.idle = first_blk ? -1 : ((pc == 0) ? (GAP + (mk_before ? 1 : 0)) : stalls);
            q.push_back(e);
            stalls = 0;
            first_blk = 1'b0;
            for (int k = 0; k < 3; k++) if (hs[k]) src_cnt[k]++;
            pc++;
            if (pc == 64) begin
                pc = 0;
                pb++;
                if (pb == NB) begin
                    pb = 0;
                    pm++;
                    dc_mcu = RESTART && (cur_ri != 0) && (pm % cur_ri == 0);
                    mk_before = dc_mcu;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input int total, input int ri, input int drops,
                             input bit abort, input bit poke);
        int n;
        bit poked;
        mcu_total = MW'(total);
`ifdef RESTART_EN
        restart_interval = MW'(ri);
`endif
        cur_ri = ri;
        q.delete();
        pb = 0; pm = 0; pc = 0;
        first_blk = 1'b1; dc_mcu = 1'b1; mk_before = 1'b0;
        stalls = 0; out_cnt = 0; fd_seen = 0; mk_cnt = 0;
        drop_left = drops; poked = 1'b0;
        fd_idle_exp = (total == 0) ? 1 : GAP;
        for (int k = 0; k < 3; k++) src_cnt[k] = 0;
        cycle(1'b0, 1'b1);
        idle_run = 0;
        chk("busy_after_start", 32'(busy), 32'(total != 0));
        n = 0;
        while (fd_seen == 0 && n < total * NB * (64 + GAP + 2) + 20) begin
            if (abort && pm == 0 && pb == YB && pc == 30) begin
                cycle(1'b1, 1'b0);
                chk("abort_outputs", 32'({out_valid, out_data, out_done, out_comp, out_chroma,
                                          out_dc_reset, busy, frame_done, src_ready}), 32'd0);
                chk("abort_q_empty", 32'(q.size()), 32'd0);
                rst = 1'b0;
                q.delete();
                return;
            end
            if (poke && !poked && pm == 0 && pb == 1 && pc == 5) begin
                mcu_total = MW'(7);
                poked = 1'b1;
                cycle(1'b0, 1'b1);
            end else begin
                cycle(1'b0, 1'b0);
            end
            n++;
        end
        chk("frame_done_seen", 32'(fd_seen), 32'd1);
        chk("frame_done_pulse", 32'(frame_done), 32'd0);
        chk("busy_after_frame", 32'(busy), 32'd0);
        chk("out_count", 32'(out_cnt), 32'(total * NB * 64));
        chk("q_empty_end", 32'(q.size()), 32'd0);
`ifdef RESTART_EN
        chk("marker_count", 32'(mk_cnt), 32'((ri != 0 && total > 0) ? (total - 1) / ri : 0));
`endif
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        mcu_total = '0;
        src_valid = 3'b000;
        src_data = '0;
`ifdef RESTART_EN
        restart_interval = '0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({out_valid, out_data, out_done, out_comp, out_chroma,
                                  out_dc_reset, busy, frame_done, src_ready}), 32'd0);
        run_frame(1, 0, 0, 1'b0, 1'b0);   // one MCU, sources always valid
        run_frame(1, 0, 3, 1'b0, 1'b0);   // Y bubble of 3 cycles at coefficient 20
        run_frame(2, 0, 0, 1'b0, 1'b1);   // two MCUs, ignored frame_start mid-frame
        run_frame(0, 0, 0, 1'b0, 1'b0);   // empty frame
        run_frame(1, 0, 0, 1'b1, 1'b0);   // reset at Cb coefficient 30
        run_frame(1, 0, 0, 1'b0, 1'b0);   // clean restart after reset
`ifdef RESTART_EN
        run_frame(10, 1, 0, 1'b0, 1'b0);
        run_frame(5, 2, 0, 1'b0, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
